uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one CoreUARTapb transmitter (non-FIFO mode) among NUM_REQ byte sources.
- Selects a requester, hands its byte to the transmit holding register, and pulses the load strobe.
- Tracks the transmitter's txrdy handshake so no byte is overwritten.
- Sits between on-chip producers (debug, console, bootloader) and the UART TX path, on the system clock.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte scheduler that feeds a single CoreUARTapb transmitter (non-FIFO mode).
// Defining UART_TX_ARB_LOCK_EN adds message locking driven by req_last.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 txrdy,
   output logic [7:0]           tx_hold_reg,
   output logic                 tx_load,
   output logic [2:0]           grant_id,
   output logic                 busy
);

   typedef enum logic [2:0] {ARB, LOAD, WAIT_LOW, GAP, WAIT_HIGH} state_t;

   localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t       state;
   logic [2:0]   rr_ptr;
   logic [15:0]  gap_cnt;

   logic [NUM_REQ-1:0] cand;
   logic [7:0]         cand_pad;
   logic [63:0]        data_pad;
   logic [3:0]         idx;
   logic               found;
   logic [2:0]         winner;
   logic [2:0]         winner_nxt;
   logic [NUM_REQ-1:0] grant_vec;

`ifdef UART_TX_ARB_LOCK_EN
   logic       locked;
   logic [2:0] lock_id;
   logic [7:0] last_pad;

   assign last_pad = 8'(req_last);

   // While locked only the owning requester is eligible.
   always_comb begin
      cand = req_valid;
      if (locked) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand[i] = (3'(i) == lock_id) ? req_valid[i] : 1'b0;
         end
      end
   end
`else
   logic unused_last;

   assign unused_last = ^req_last;
   assign cand        = req_valid;
`endif

   assign cand_pad = 8'(cand);
   assign data_pad = 64'(req_data);

   // Search upward from rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + 4'(i);
         if (idx >= 4'(NUM_REQ)) begin
            idx = idx - 4'(NUM_REQ);
         end
         if (!found && cand_pad[idx[2:0]]) begin
            found  = 1'b1;
            winner = idx[2:0];
         end
      end
   end

   assign winner_nxt = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;

   always_comb begin
      grant_vec = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         grant_vec[i] = (3'(i) == winner);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ARB;
         rr_ptr      <= '0;
         gap_cnt     <= '0;
         req_ready   <= '0;
         tx_hold_reg <= '0;
         tx_load     <= 1'b0;
         grant_id    <= '0;
         busy        <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
         locked      <= 1'b0;
         lock_id     <= '0;
`endif
      end else begin
         req_ready <= '0;
         tx_load   <= 1'b0;
         case (state)
            ARB: begin
               if (txrdy && found) begin
                  req_ready   <= grant_vec;
                  tx_hold_reg <= data_pad[{winner, 3'b000} +: 8];
                  grant_id    <= winner;
                  busy        <= 1'b1;
                  state       <= LOAD;
`ifdef UART_TX_ARB_LOCK_EN
                  // The pointer only moves when a message completes.
                  if (last_pad[winner]) begin
                     locked <= 1'b0;
                     rr_ptr <= winner_nxt;
                  end else begin
                     locked  <= 1'b1;
                     lock_id <= winner;
                  end
`else
                  rr_ptr <= winner_nxt;
`endif
               end
            end
            LOAD: begin
               tx_load <= 1'b1;
               state   <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!txrdy) begin
                  gap_cnt <= '0;
                  state   <= (GAP_CYCLES > 0) ? GAP : WAIT_HIGH;
               end
            end
            GAP: begin
               if (txrdy) begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     state   <= ARB;
                     busy    <= 1'b0;
                  end else begin
                     gap_cnt <= gap_cnt + 16'd1;
                  end
               end else begin
                  gap_cnt <= '0;
               end
            end
            WAIT_HIGH: begin
               if (txrdy) begin
                  state <= ARB;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ARB;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one default instance and one with a 5-cycle gap.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic [3:0]  r_valid = '0;
   logic [31:0] r_data = '0;
   logic [3:0]  r_last = '0;
   logic [3:0]  r_ready;
   logic        txrdy;
   logic        man_txrdy = 1'b1;
   logic        model_txrdy = 1'b1;
   logic        model_en = 1'b0;
   logic [7:0]  hold;
   logic        load;
   logic [2:0]  gid;
   logic        busy;

   logic [3:0]  g_valid = '0;
   logic [31:0] g_data = '0;
   logic [3:0]  g_last = '0;
   logic [3:0]  g_ready;
   logic        g_txrdy = 1'b1;
   logic [7:0]  g_hold;
   logic        g_load;
   logic [2:0]  g_gid;
   logic        g_busy;

   int n_cmp = 0;
   int n_err = 0;
   int frame_cnt = 0;
   logic [7:0] bytes_q[$];

   always #5 clk = ~clk;

   assign txrdy = model_en ? model_txrdy : man_txrdy;

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .reset_n(reset_n), .req_valid(r_valid), .req_data(r_data),
      .req_last(r_last), .req_ready(r_ready), .txrdy(txrdy), .tx_hold_reg(hold),
      .tx_load(load), .grant_id(gid), .busy(busy));

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(5)) u_gap (
      .clk(clk), .reset_n(reset_n), .req_valid(g_valid), .req_data(g_data),
      .req_last(g_last), .req_ready(g_ready), .txrdy(g_txrdy), .tx_hold_reg(g_hold),
      .tx_load(g_load), .grant_id(g_gid), .busy(g_busy));

   // Transmitter model: captures each loaded byte, holds txrdy low for a 10-cycle frame.
   always @(posedge clk) begin
      if (model_en) begin
         if (load) begin
            bytes_q.push_back(hold);
            model_txrdy <= 1'b0;
            frame_cnt   <= 10;
         end else if (frame_cnt > 0) begin
            frame_cnt <= frame_cnt - 1;
            if (frame_cnt == 1) model_txrdy <= 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] gq[$];
      logic [3:0] rq[$];
      logic [2:0] gq2[$];
      logic [2:0] exp_seq[4];
      int base;
      int n;
      int k1;
      logic seen;
      logic got;

      // Reset state
      tick();
      chk("rst_ready", 32'(r_ready), 32'h0);
      chk("rst_hold", 32'(hold), 32'h0);
      chk("rst_load", 32'(load), 32'h0);
      chk("rst_gid", 32'(gid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset_n = 1'b1;

      // Idle with txrdy high: nothing happens
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (load || r_ready != 0 || busy) seen = 1'b1;
      end
      chk("idle_quiet", 32'(seen), 32'h0);

      // Requester 2 sends 0xA5
      r_valid = 4'b0100;
      r_data[23:16] = 8'hA5;
      tick();
      chk("r2_ready", 32'(r_ready), 32'h4);
      chk("r2_hold", 32'(hold), 32'hA5);
      chk("r2_gid", 32'(gid), 32'h2);
      chk("r2_load_early", 32'(load), 32'h0);
      chk("r2_busy", 32'(busy), 32'h1);
      r_valid = '0;
      tick();
      chk("r2_load", 32'(load), 32'h1);
      chk("r2_ready_drop", 32'(r_ready), 32'h0);
      chk("r2_hold_stable", 32'(hold), 32'hA5);
      tick();
      chk("r2_load_once", 32'(load), 32'h0);
      r_valid = 4'b0100;
      r_data[23:16] = 8'h5A;
      seen = 1'b0;
      repeat (3) begin tick(); if (r_ready != 0) seen = 1'b1; end
      man_txrdy = 1'b0;
      repeat (2) begin tick(); if (r_ready != 0) seen = 1'b1; end
      chk("no_grant_until_txrdy_cycle", 32'(seen), 32'h0);
      chk("hold_unchanged", 32'(hold), 32'hA5);
      man_txrdy = 1'b1;
      tick();
      chk("txrdy_rise_arb", 32'(r_ready), 32'h0);
      chk("txrdy_rise_idle_busy", 32'(busy), 32'h0);
      tick();
      chk("second_grant", 32'(r_ready), 32'h4);
      chk("second_hold", 32'(hold), 32'h5A);
      r_valid = '0;
      tick();
      man_txrdy = 1'b0;
      tick();
      man_txrdy = 1'b1;
      tick();

      // Round robin with all four valid, transmitter model looping
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      base = bytes_q.size();
      r_data = 32'h13121110;
      r_valid = 4'b1111;
      model_en = 1'b1;
      for (int c = 0; c < 400 && gq.size() < 5; c++) begin
         tick();
         if (r_ready != 0) begin
            gq.push_back(gid);
            rq.push_back(r_ready);
         end
         if (gq.size() == 5) r_valid = '0;
      end
      r_valid = '0;
      repeat (20) tick();
      chk("rr_grant_count", 32'(gq.size()), 32'd5);
      while (gq.size() < 5) begin gq.push_back(3'h7); rq.push_back(4'h0); end
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr_gid%0d", k), 32'(gq[k]), 32'(k % 4));
         chk($sformatf("rr_ready%0d", k), 32'(rq[k]), 32'(4'b0001 << (k % 4)));
         chk($sformatf("rr_byte%0d", k),
             (bytes_q.size() > base + k) ? 32'(bytes_q[base + k]) : 32'hFFFF_FFFF,
             32'(8'h10 + k % 4));
      end
      model_en = 1'b0;
      man_txrdy = 1'b1;

      // Gap instance: second grant exactly 6 edges after txrdy rises
      g_txrdy = 1'b1;
      g_valid = 4'b0001;
      g_data[7:0] = 8'h33;
      tick();
      chk("gap_first_ready", 32'(g_ready), 32'h1);
      chk("gap_first_hold", 32'(g_hold), 32'h33);
      g_data[7:0] = 8'h34;
      tick();
      chk("gap_first_load", 32'(g_load), 32'h1);
      tick();
      g_txrdy = 1'b0;
      tick();
      tick();
      tick();
      g_txrdy = 1'b1;
      n = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         n++;
         if (g_ready != 0) got = 1'b1;
      end
      chk("gap_latency", 32'(n), 32'd6);
      chk("gap_second_hold", 32'(g_hold), 32'h34);
      g_data[7:0] = 8'h35;
      tick();
      tick();
      g_txrdy = 1'b0;
      tick();
      g_txrdy = 1'b1;
      seen = 1'b0;
      repeat (3) begin tick(); if (g_ready != 0) seen = 1'b1; end
      g_txrdy = 1'b0;
      tick();
      if (g_ready != 0) seen = 1'b1;
      chk("gap_glitch_no_grant", 32'(seen), 32'h0);
      g_txrdy = 1'b1;
      n = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         n++;
         if (g_ready != 0) got = 1'b1;
      end
      chk("gap_restart_latency", 32'(n), 32'd6);
      chk("gap_third_hold", 32'(g_hold), 32'h35);
      g_valid = '0;
      tick();
      tick();
      g_txrdy = 1'b0;
      tick();
      g_txrdy = 1'b1;
      repeat (7) tick();

      // Reset during LOAD
      r_valid = 4'b1000;
      r_data[31:24] = 8'h77;
      tick();
      chk("pre_rst_ready", 32'(r_ready), 32'h8);
      reset_n = 1'b0;
      #1;
      chk("load_rst_load", 32'(load), 32'h0);
      chk("load_rst_ready", 32'(r_ready), 32'h0);
      chk("load_rst_hold", 32'(hold), 32'h0);
      chk("load_rst_busy", 32'(busy), 32'h0);
      tick();
      chk("load_rst_no_pulse", 32'(load), 32'h0);
      reset_n = 1'b1;
      r_valid = 4'b1001;
      r_data[7:0] = 8'h55;
      tick();
      chk("tie_ready", 32'(r_ready), 32'h1);
      chk("tie_gid", 32'(gid), 32'h0);
      chk("tie_hold", 32'(hold), 32'h55);
      r_valid = '0;
      tick();
      chk("tie_load", 32'(load), 32'h1);
      man_txrdy = 1'b0;
      tick();
      tick();
      man_txrdy = 1'b1;
      tick();
      tick();

      // Message sequence: requester 1 sends 3 bytes while requester 0 stays valid
`ifdef UART_TX_ARB_LOCK_EN
      exp_seq = '{3'd1, 3'd1, 3'd1, 3'd0};
`else
      exp_seq = '{3'd1, 3'd0, 3'd1, 3'd0};
`endif
      r_data[7:0] = 8'h20;
      r_data[15:8] = 8'h40;
      r_last = '0;
      r_valid = 4'b0011;
      k1 = 0;
      model_en = 1'b1;
      for (int c = 0; c < 600 && gq2.size() < 4; c++) begin
         tick();
         if (r_ready != 0) gq2.push_back(gid);
         if (r_ready[1]) begin
            k1++;
            if (k1 == 1) r_data[15:8] = 8'h41;
            if (k1 == 2) begin r_data[15:8] = 8'h42; r_last[1] = 1'b1; end
            if (k1 == 3) r_valid[1] = 1'b0;
         end
         if (gq2.size() == 4) r_valid = '0;
      end
      r_valid = '0;
      repeat (20) tick();
      chk("seq_count", 32'(gq2.size()), 32'd4);
      while (gq2.size() < 4) gq2.push_back(3'h7);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("seq_gid%0d", k), 32'(gq2[k]), 32'(exp_seq[k]));
      end
      model_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
